// File: rtl/apb_master_if.sv
// Command/response port and APB bus of apb_master, bundled with a master view
// (the initiator) and a slave view (the local controller plus the completer).
interface apb_master_if #(
    parameter int WDATA = 8,
    parameter int WADDR = 8
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_write;
    logic [WADDR-1:0] i_req_addr;
    logic [WDATA-1:0] i_req_wdata;

    logic             o_rsp_valid;
    logic [WDATA-1:0] o_rsp_rdata;
    logic             o_rsp_err;
    logic             o_rsp_timeout;

    logic             o_PSEL;
    logic             o_PENABLE;
    logic             o_PWRITE;
    logic [WADDR-1:0] o_PADDR;
    logic [WDATA-1:0] o_PWDATA;
    logic             i_PREADY;
    logic             i_PSLVERR;
    logic [WDATA-1:0] i_PRDATA;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  i_PREADY, i_PSLVERR, i_PRDATA,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        output o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output i_PREADY, i_PSLVERR, i_PRDATA,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        input  o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// Single-channel APB initiator: valid/ready commands become SETUP/ACCESS transfers,
// each answered by a one-cycle response pulse; optional PREADY timeout.
module apb_master #(
    parameter int WDATA   = 8,
    parameter int WADDR   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         i_PCLK,
    input  logic         i_PRESET,
    apb_master_if.master bus
);
    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [WADDR-1:0] paddr_q, paddr_d;
    logic [WDATA-1:0] pwdata_q, pwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WDATA-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic timeout_hit;
    logic xfer_end;
    logic req_ready;
    logic accept;

    // With TIMEOUT=0 the counter is pinned at 0 and the hit term is constant-false.
    assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && !bus.i_PREADY
                         && (cnt_q == CNT_MAX);
    assign xfer_end    = (state_q == ACCESS) && (bus.i_PREADY || timeout_hit);
    assign req_ready   = (state_q == IDLE) || xfer_end;
    assign accept      = bus.i_req_valid && req_ready;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (xfer_end) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (bus.i_PREADY && !pwrite_q) ? bus.i_PRDATA : '0;
                    rsp_err_d     = bus.i_PREADY ? bus.i_PSLVERR : 1'b1;
                    rsp_timeout_d = !bus.i_PREADY;
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Acceptance only happens in IDLE or in the last ACCESS cycle; both go to SETUP.
        if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = bus.i_req_write;
            paddr_d   = bus.i_req_addr;
            pwdata_d  = bus.i_req_wdata;
        end
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_PSEL        = psel_q;
    assign bus.o_PENABLE     = penable_q;
    assign bus.o_PWRITE      = pwrite_q;
    assign bus.o_PADDR       = paddr_q;
    assign bus.o_PWDATA      = pwdata_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;
    assign bus.o_rsp_err     = rsp_err_q;
    assign bus.o_rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus random traffic against a memory
// completer with random wait states/errors and a transaction-level response model.
module tb_apb_master;
    localparam int TO_MAIN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    apb_master_if #(.WDATA(8), .WADDR(8)) bus  ();
    apb_master_if #(.WDATA(8), .WADDR(8)) bus4 ();
    apb_master_if #(.WDATA(8), .WADDR(8)) bus0 ();

    apb_master #(.WDATA(8), .WADDR(8), .TIMEOUT(TO_MAIN)) dut  (.i_PCLK(clk), .i_PRESET(rst), .bus(bus));
    apb_master #(.WDATA(8), .WADDR(8), .TIMEOUT(4))       dut4 (.i_PCLK(clk), .i_PRESET(rst), .bus(bus4));
    apb_master #(.WDATA(8), .WADDR(8), .TIMEOUT(0))       dut0 (.i_PCLK(clk), .i_PRESET(rst), .bus(bus0));

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         cyc;
    } cmd_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         cyc;
    } rsp_t;

    cmd_t       cmd_q[$];
    rsp_t       exp_q[$];
    rsp_t       rsp_log[$];
    logic [7:0] mem[int];

    // Completer behaviour: mode 0 random, mode 1 fixed wait/err (and optionally rdata).
    int         mode = 1;
    int         fix_wait = 1;
    logic       fix_err = 1'b0;
    logic       fix_rdata_en = 1'b0;
    logic [7:0] fix_rdata = 8'h00;

    cmd_t       cur;
    logic       in_xfer = 1'b0;
    int         acc_n = 0;
    int         wait_n = 0;
    logic       err_n = 1'b0;
    rsp_t       mon_e;
    rsp_t       mon_p;
    int         rsp_count = 0;
    int         last_rsp_cyc = 0;
    int         last_acc = 0;

    // Completer, bus-phase expectations and response scoreboard for the main instance.
    always @(negedge clk) begin
        if (rst) begin
            bus.i_PREADY  = 1'b0;
            bus.i_PSLVERR = 1'b0;
            bus.i_PRDATA  = 8'h00;
            cmd_q.delete();
            exp_q.delete();
            in_xfer = 1'b0;
        end else begin
            if (bus.o_rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
                mon_p.rdata = bus.o_rsp_rdata;
                mon_p.err   = bus.o_rsp_err;
                mon_p.to    = bus.o_rsp_timeout;
                mon_p.cyc   = cyc;
                rsp_log.push_back(mon_p);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", bus.o_rsp_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_cycle", cyc, mon_e.cyc);
                    check("rsp_rdata", bus.o_rsp_rdata, mon_e.rdata);
                    check("rsp_err", bus.o_rsp_err, mon_e.err);
                    check("rsp_timeout", bus.o_rsp_timeout, mon_e.to);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("rsp_missing", bus.o_rsp_valid, 1'b1);
                void'(exp_q.pop_front());
            end

            bus.i_PREADY  = 1'b0;
            bus.i_PSLVERR = 1'($urandom_range(0, 1));
            bus.i_PRDATA  = 8'($urandom);

            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc - 1) begin
                cur = cmd_q.pop_front();
                check("setup_psel", bus.o_PSEL, 1'b1);
                check("setup_penable", bus.o_PENABLE, 1'b0);
                check("setup_paddr", bus.o_PADDR, cur.a);
                check("setup_pwrite", bus.o_PWRITE, cur.w);
                if (cur.w) check("setup_pwdata", bus.o_PWDATA, cur.d);
                in_xfer = 1'b1;
                acc_n   = 0;
                if (mode == 1) begin
                    wait_n = fix_wait;
                    err_n  = fix_err;
                end else begin
                    int r;
                    r      = $urandom_range(0, 9);
                    wait_n = (r < 3) ? 0 : (r < 9) ? $urandom_range(1, 4)
                                                   : $urandom_range(TO_MAIN - 1, TO_MAIN + 2);
                    err_n  = ($urandom_range(0, 7) == 0);
                end
            end else if (in_xfer) begin
                acc_n++;
                check("access_psel", bus.o_PSEL, 1'b1);
                check("access_penable", bus.o_PENABLE, 1'b1);
                check("access_paddr", bus.o_PADDR, cur.a);
                check("access_pwrite", bus.o_PWRITE, cur.w);
                if (acc_n == wait_n + 1) begin
                    bus.i_PREADY  = 1'b1;
                    bus.i_PSLVERR = err_n;
                    if (mode == 1 && fix_rdata_en) bus.i_PRDATA = fix_rdata;
                    else bus.i_PRDATA = mem.exists(int'(cur.a)) ? mem[int'(cur.a)] : 8'h00;
                    mon_p.rdata = cur.w ? 8'h00 : bus.i_PRDATA;
                    mon_p.err   = err_n;
                    mon_p.to    = 1'b0;
                    mon_p.cyc   = cyc + 1;
                    exp_q.push_back(mon_p);
                    if (cur.w && !err_n) mem[int'(cur.a)] = cur.d;
                    in_xfer = 1'b0;
                end else if (acc_n == TO_MAIN + 1) begin
                    mon_p.rdata = 8'h00;
                    mon_p.err   = 1'b1;
                    mon_p.to    = 1'b1;
                    mon_p.cyc   = cyc + 1;
                    exp_q.push_back(mon_p);
                    in_xfer = 1'b0;
                end
            end else begin
                check("idle_psel", bus.o_PSEL, 1'b0);
                check("idle_penable", bus.o_PENABLE, 1'b0);
            end
        end
    end

    // Call at a negedge; returns at the negedge after acceptance with valid dropped.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
        int   budget;
        cmd_t c;
        bus.i_req_valid = 1'b1;
        bus.i_req_write = w;
        bus.i_req_addr  = a;
        bus.i_req_wdata = d;
        #1;
        budget = 0;
        while (!bus.o_req_ready && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("req_accept", bus.o_req_ready, 1'b1);
        if (bus.o_req_ready) begin
            c.w = w; c.a = a; c.d = d; c.cyc = cyc;
            cmd_q.push_back(c);
            last_acc = cyc;
        end
        @(negedge clk);
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t r, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.o_rsp_valid && n < 200);
        check("rsp_arrived", bus.o_rsp_valid, 1'b1);
        r.rdata = bus.o_rsp_rdata;
        r.err   = bus.o_rsp_err;
        r.to    = bus.o_rsp_timeout;
        r.cyc   = cyc;
        lat     = cyc - last_acc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsp_t r;
        int   lat, t0, base, n, cnt0, n0;

        bus.i_req_valid  = 1'b0; bus.i_req_write  = 1'b0; bus.i_req_addr  = '0; bus.i_req_wdata  = '0;
        bus4.i_req_valid = 1'b0; bus4.i_req_write = 1'b0; bus4.i_req_addr = '0; bus4.i_req_wdata = '0;
        bus0.i_req_valid = 1'b0; bus0.i_req_write = 1'b0; bus0.i_req_addr = '0; bus0.i_req_wdata = '0;
        bus4.i_PREADY = 1'b0; bus4.i_PSLVERR = 1'b0; bus4.i_PRDATA = '0;
        bus0.i_PREADY = 1'b0; bus0.i_PSLVERR = 1'b0; bus0.i_PRDATA = '0;

        repeat (3) @(negedge clk);
        check("rst_psel", bus.o_PSEL, 1'b0);
        check("rst_penable", bus.o_PENABLE, 1'b0);
        check("rst_pwrite", bus.o_PWRITE, 1'b0);
        check("rst_paddr", bus.o_PADDR, 8'h00);
        check("rst_pwdata", bus.o_PWDATA, 8'h00);
        check("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.o_rsp_rdata, 8'h00);
        check("rst_rsp_err", bus.o_rsp_err, 1'b0);
        check("rst_rsp_timeout", bus.o_rsp_timeout, 1'b0);
        check("rst_req_ready", bus.o_req_ready, 1'b1);
        rst = 1'b0;

        // Write 0xA5 to 0x10 with one wait state, like a registered-PREADY completer.
        mode = 1; fix_wait = 1; fix_err = 1'b0; fix_rdata_en = 1'b0;
        @(negedge clk);
        send(1'b1, 8'h10, 8'hA5);
        #1;
        check("wr_t1_psel", bus.o_PSEL, 1'b1);
        check("wr_t1_penable", bus.o_PENABLE, 1'b0);
        @(negedge clk); #1;
        check("wr_t2_penable", bus.o_PENABLE, 1'b1);
        wait_rsp(r, lat);
        check("wr_latency", lat, 4);
        check("wr_err", r.err, 1'b0);
        check("wr_rdata", r.rdata, 8'h00);

        // Read it back; address must hold through SETUP and ACCESS.
        @(negedge clk);
        send(1'b0, 8'h10, 8'h00);
        #1; check("rd_paddr_t1", bus.o_PADDR, 8'h10);
        @(negedge clk); #1; check("rd_paddr_t2", bus.o_PADDR, 8'h10);
        @(negedge clk); #1; check("rd_paddr_t3", bus.o_PADDR, 8'h10);
        wait_rsp(r, lat);
        check("rd_latency", lat, 4);
        check("rd_rdata", r.rdata, 8'hA5);
        check("rd_err", r.err, 1'b0);
        check("rd_timeout", r.to, 1'b0);

        // Back-to-back: three writes then three reads, valid held high throughout.
        @(negedge clk);
        cnt0 = rsp_count;
        base = rsp_log.size();
        send(1'b1, 8'h01, 8'h11);
        t0 = last_acc;
        send(1'b1, 8'h02, 8'h22);
        send(1'b1, 8'h03, 8'h33);
        send(1'b0, 8'h01, 8'h00);
        send(1'b0, 8'h02, 8'h00);
        send(1'b0, 8'h03, 8'h00);
        n = 0;
        while (rsp_count - cnt0 < 6 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("b2b_count", rsp_count - cnt0, 6);
        check("b2b_span", last_rsp_cyc - t0, 19);
        if (rsp_log.size() >= base + 6) begin
            check("b2b_rd1", rsp_log[base+3].rdata, 8'h11);
            check("b2b_rd2", rsp_log[base+4].rdata, 8'h22);
            check("b2b_rd3", rsp_log[base+5].rdata, 8'h33);
        end

        // Five wait states then an erroring completion with data 0x3C.
        fix_wait = 5; fix_err = 1'b1; fix_rdata_en = 1'b1; fix_rdata = 8'h3C;
        @(negedge clk);
        send(1'b0, 8'h20, 8'h00);
        wait_rsp(r, lat);
        check("ws_latency", lat, 8);
        check("ws_err", r.err, 1'b1);
        check("ws_rdata", r.rdata, 8'h3C);
        check("ws_timeout", r.to, 1'b0);

        // Reset in the middle of ACCESS.
        fix_wait = 10; fix_err = 1'b0; fix_rdata_en = 1'b0;
        @(negedge clk);
        send(1'b1, 8'h30, 8'h77);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst  = 1'b1;
        cnt0 = rsp_count;
        @(negedge clk); #1;
        check("mid_rst_psel", bus.o_PSEL, 1'b0);
        check("mid_rst_penable", bus.o_PENABLE, 1'b0);
        check("mid_rst_pwrite", bus.o_PWRITE, 1'b0);
        check("mid_rst_paddr", bus.o_PADDR, 8'h00);
        check("mid_rst_pwdata", bus.o_PWDATA, 8'h00);
        check("mid_rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        check("mid_rst_rsp_rdata", bus.o_rsp_rdata, 8'h00);
        check("mid_rst_rsp_err", bus.o_rsp_err, 1'b0);
        check("mid_rst_rsp_timeout", bus.o_rsp_timeout, 1'b0);
        check("mid_rst_req_ready", bus.o_req_ready, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_no_rsp", rsp_count - cnt0, 0);
        fix_wait = 1;
        send(1'b0, 8'h10, 8'h00);
        wait_rsp(r, lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_rdata", r.rdata, 8'hA5);

        // Random traffic: mixed gaps, random waits (some around the timeout), random errors.
        mode = 0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        n = 0;
        while ((exp_q.size() > 0 || cmd_q.size() > 0 || in_xfer) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rand_drained", exp_q.size() + cmd_q.size(), 0);

        // TIMEOUT=4, PREADY stuck low: abort in ACCESS cycle 5, response the cycle after.
        @(negedge clk);
        bus4.i_req_valid = 1'b1;
        bus4.i_req_addr  = 8'h44;
        #1;
        check("t4_ready_idle", bus4.o_req_ready, 1'b1);
        @(negedge clk);
        bus4.i_req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check("t4_psel", bus4.o_PSEL, (k <= 6));
            check("t4_penable", bus4.o_PENABLE, (k >= 2 && k <= 6));
            check("t4_ready", bus4.o_req_ready, (k >= 6));
            check("t4_rsp_valid", bus4.o_rsp_valid, (k == 7));
            if (k == 7) begin
                check("t4_rsp_err", bus4.o_rsp_err, 1'b1);
                check("t4_rsp_timeout", bus4.o_rsp_timeout, 1'b1);
                check("t4_rsp_rdata", bus4.o_rsp_rdata, 8'h00);
            end
            @(negedge clk);
        end

        // TIMEOUT=0, PREADY stuck low: the transfer waits forever.
        bus0.i_req_valid = 1'b1;
        bus0.i_req_write = 1'b1;
        bus0.i_req_addr  = 8'h55;
        @(negedge clk);
        bus0.i_req_valid = 1'b0;
        n0 = 0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (bus0.o_rsp_valid) n0++;
        end
        check("t0_no_rsp", n0, 0);
        check("t0_psel_held", bus0.o_PSEL, 1'b1);
        check("t0_penable_held", bus0.o_PENABLE, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
